// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, ALU, RV32I branch/JALR resolution, iterative MUL/MULHU, E->M register.
// Optional EXEC_PERF_CNT_EN adds saturating stall_cnt / mul_cnt outputs.
module execute_stage_mc #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_e,
   output logic            ready_e,
   input  logic            flush_e,
   input  logic            stall_m,
   input  logic            reg_write_e,
   input  logic            mem_write_e,
   input  logic            result_src_e,
   input  logic            alu_src_e,
   input  logic            branch_e,
   input  logic            jump_e,
   input  logic            jalr_e,
   input  logic [2:0]      br_funct3,
   input  logic [3:0]      alu_ctrl_e,
   input  logic [XLEN-1:0] rd1_e,
   input  logic [XLEN-1:0] rd2_e,
   input  logic [XLEN-1:0] imm_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] pc_plus4_e,
   input  logic [RA_W-1:0] rd_e,
   input  logic [XLEN-1:0] result_w,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   output logic            pc_src_e,
   output logic [XLEN-1:0] pc_target_e,
   output logic            valid_m,
   output logic            reg_write_m,
   output logic            mem_write_m,
   output logic            result_src_m,
   output logic [RA_W-1:0] rd_m,
   output logic [XLEN-1:0] pc_plus4_m,
   output logic [XLEN-1:0] write_data_m,
   output logic [XLEN-1:0] alu_result_m,
   output logic            busy
`ifdef EXEC_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     mul_cnt
`endif
);

   localparam int SH_W = $clog2(XLEN);

   // Handshake: the E instruction retires on a rising edge where valid_e & ready_e & !flush_e;
   // while ready_e is 0 upstream holds every E input stable.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [XLEN-1:0]   src_a;
   logic [XLEN-1:0]   fwd_b_val;
   logic [XLEN-1:0]   src_b;
   logic [XLEN-1:0]   alu_y;
   logic [XLEN-1:0]   jalr_sum;
   logic [SH_W-1:0]   shamt;
   logic              cond;
   logic              mul_op;
   logic              mul_accept;
   logic              retire;
   logic [2*XLEN-1:0] mcand;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mplier;
   logic [SH_W-1:0]   cnt;

   // Forwarding muxes
   always_comb begin
      case (fwd_a)
         2'b01:   src_a = result_w;
         2'b10:   src_a = alu_result_m;
         default: src_a = rd1_e;
      endcase
   end

   always_comb begin
      case (fwd_b)
         2'b01:   fwd_b_val = result_w;
         2'b10:   fwd_b_val = alu_result_m;
         default: fwd_b_val = rd2_e;
      endcase
   end

   assign src_b  = alu_src_e ? imm_e : fwd_b_val;
   assign shamt  = src_b[SH_W-1:0];
   assign mul_op = (alu_ctrl_e == 4'd10) || (alu_ctrl_e == 4'd11);

   // MUL/MULHU read the accumulator; it only holds a finished product in DONE, the only retire point.
   always_comb begin
      alu_y = '0;
      case (alu_ctrl_e)
         4'd0:    alu_y = src_a + src_b;
         4'd1:    alu_y = src_a - src_b;
         4'd2:    alu_y = src_a & src_b;
         4'd3:    alu_y = src_a | src_b;
         4'd4:    alu_y = src_a ^ src_b;
         4'd5:    alu_y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'd6:    alu_y = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         4'd7:    alu_y = src_a << shamt;
         4'd8:    alu_y = src_a >> shamt;
         4'd9:    alu_y = $signed(src_a) >>> shamt;
         4'd10:   alu_y = acc[XLEN-1:0];
         4'd11:   alu_y = acc[2*XLEN-1:XLEN];
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      case (br_funct3)
         3'b000:  cond = (src_a == fwd_b_val);
         3'b001:  cond = (src_a != fwd_b_val);
         3'b100:  cond = ($signed(src_a) < $signed(fwd_b_val));
         3'b101:  cond = ($signed(src_a) >= $signed(fwd_b_val));
         3'b110:  cond = (src_a < fwd_b_val);
         3'b111:  cond = (src_a >= fwd_b_val);
         default: cond = 1'b0;
      endcase
   end

   assign jalr_sum    = src_a + imm_e;
   assign pc_target_e = jalr_e ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_e + imm_e);
   assign pc_src_e    = retire & (jump_e | (branch_e & cond));

   // Multiplier FSM
   assign mul_accept = (state == S_IDLE) & valid_e & ~flush_e & ~stall_m & mul_op;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (mul_accept) state_nx = S_MUL;
         S_MUL: begin
            if (flush_e)                          state_nx = S_IDLE;
            else if (cnt == SH_W'(XLEN-1))        state_nx = S_DONE;
         end
         S_DONE: if (flush_e || !stall_m) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      ready_e = 1'b0;
      busy    = 1'b0;
      case (state)
         S_IDLE: ready_e = !stall_m && !mul_accept;
         S_MUL:  busy    = 1'b1;
         S_DONE: begin
            ready_e = !stall_m;
            busy    = 1'b1;
         end
         default: begin
            ready_e = 1'b0;
            busy    = 1'b0;
         end
      endcase
   end

   assign retire = valid_e & ready_e & ~flush_e;

   // Shift-add datapath: multiplicand walks left, multiplier walks right, one bit per edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mul_accept) begin
                  mcand  <= {{XLEN{1'b0}}, src_a};
                  mplier <= src_b;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            S_MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // E->M register; data fields keep their old value through bubbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_m      <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= 1'b0;
         rd_m         <= '0;
         pc_plus4_m   <= '0;
         write_data_m <= '0;
         alu_result_m <= '0;
      end else if (!stall_m) begin
         valid_m     <= retire;
         reg_write_m <= retire & reg_write_e;
         mem_write_m <= retire & mem_write_e;
         if (retire) begin
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_plus4_e;
            write_data_m <= fwd_b_val;
            alu_result_m <= alu_y;
         end
      end
   end

`ifdef EXEC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         mul_cnt   <= '0;
      end else begin
         if (valid_e && !ready_e && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (retire && (state == S_DONE) && (mul_cnt != '1))
            mul_cnt <= mul_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized and directed bench for execute_stage_mc against a transaction-level reference model.
module tb_execute_stage_mc;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   logic            clk;
   logic            rst;
   logic            valid_e;
   logic            ready_e;
   logic            flush_e;
   logic            stall_m;
   logic            reg_write_e;
   logic            mem_write_e;
   logic            result_src_e;
   logic            alu_src_e;
   logic            branch_e;
   logic            jump_e;
   logic            jalr_e;
   logic [2:0]      br_funct3;
   logic [3:0]      alu_ctrl_e;
   logic [XLEN-1:0] rd1_e;
   logic [XLEN-1:0] rd2_e;
   logic [XLEN-1:0] imm_e;
   logic [XLEN-1:0] pc_e;
   logic [XLEN-1:0] pc_plus4_e;
   logic [RA_W-1:0] rd_e;
   logic [XLEN-1:0] result_w;
   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;
   logic            pc_src_e;
   logic [XLEN-1:0] pc_target_e;
   logic            valid_m;
   logic            reg_write_m;
   logic            mem_write_m;
   logic            result_src_m;
   logic [RA_W-1:0] rd_m;
   logic [XLEN-1:0] pc_plus4_m;
   logic [XLEN-1:0] write_data_m;
   logic [XLEN-1:0] alu_result_m;
   logic            busy;
`ifdef EXEC_PERF_CNT_EN
   logic [31:0]     stall_cnt;
   logic [31:0]     mul_cnt;
`endif

   execute_stage_mc #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst), .valid_e(valid_e), .ready_e(ready_e), .flush_e(flush_e),
      .stall_m(stall_m), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
      .result_src_e(result_src_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
      .jump_e(jump_e), .jalr_e(jalr_e), .br_funct3(br_funct3), .alu_ctrl_e(alu_ctrl_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
      .rd_e(rd_e), .result_w(result_w), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .valid_m(valid_m),
      .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
      .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m),
      .alu_result_m(alu_result_m), .busy(busy)
`ifdef EXEC_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .mul_cnt(mul_cnt)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard and model of the M register
   int              n_vec;
   int              n_err;
   logic [XLEN-1:0] exp_q[$];
   logic            m_valid, m_rw, m_mw, m_rs;
   logic [RA_W-1:0] m_rd;
   logic [XLEN-1:0] m_pc4, m_wd, m_alu;
   int              obs_low;
   logic            obs_pc_src;
   logic [XLEN-1:0] obs_target;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = '0;
      m_pc4 = '0; m_wd = '0; m_alu = '0;
   endtask

   function automatic logic [XLEN-1:0] fwd_val(input logic [1:0] sel, input logic [XLEN-1:0] reg_v);
      case (sel)
         2'b01:   return result_w;
         2'b10:   return m_alu;
         default: return reg_v;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] p;
      int unsigned       sh;
      logic [XLEN-1:0]   r;
      p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      sh = b % XLEN;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd6:    r = {{(XLEN-1){1'b0}}, (a < b)};
         4'd7:    r = a << sh;
         4'd8:    r = a >> sh;
         4'd9:    r = $signed(a) >>> sh;
         4'd10:   r = p[XLEN-1:0];
         4'd11:   r = p[2*XLEN-1:XLEN];
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic br_ref(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (f)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_m();
      check("valid_m", valid_m, m_valid);
      check("reg_write_m", reg_write_m, m_rw);
      check("mem_write_m", mem_write_m, m_mw);
      if (m_valid) begin
         check("alu_result_m", alu_result_m, m_alu);
         check("rd_m", rd_m, m_rd);
         check("result_src_m", result_src_m, m_rs);
         check("pc_plus4_m", pc_plus4_m, m_pc4);
         check("write_data_m", write_data_m, m_wd);
      end
   endtask

   // Driver tasks
   task automatic clear_fields();
      valid_e = 1; flush_e = 0; stall_m = 0;
      reg_write_e = 1; mem_write_e = 0; result_src_e = 0; alu_src_e = 0;
      branch_e = 0; jump_e = 0; jalr_e = 0; br_funct3 = 3'b010; alu_ctrl_e = 4'd0;
      rd1_e = '0; rd2_e = '0; imm_e = '0; pc_e = '0; pc_plus4_e = 32'd4;
      rd_e = 5'd1; result_w = '0; fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   task automatic rand_fields();
      valid_e = 1; flush_e = 0;
      alu_ctrl_e = 4'($urandom_range(0, 15));
      alu_src_e = ((alu_ctrl_e == 4'd10) || (alu_ctrl_e == 4'd11)) ? 1'b0 : 1'($urandom_range(0, 1));
      fwd_a = 2'($urandom_range(0, 3));
      fwd_b = 2'($urandom_range(0, 3));
      rd1_e = $urandom();
      rd2_e = ($urandom_range(0, 7) == 0) ? rd1_e : $urandom();
      result_w = $urandom();
      imm_e = ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 4095)) : $urandom();
      pc_e = $urandom() & 32'hFFFF_FFFC;
      pc_plus4_e = pc_e + 32'd4;
      branch_e = 1'($urandom_range(0, 1));
      jump_e = ($urandom_range(0, 3) == 0);
      jalr_e = 1'($urandom_range(0, 1));
      br_funct3 = 3'($urandom_range(0, 7));
      rd_e = 5'($urandom_range(0, 31));
      reg_write_e = 1'($urandom_range(0, 1));
      mem_write_e = 1'($urandom_range(0, 1));
      result_src_e = 1'($urandom_range(0, 1));
   endtask

   // Present the current E fields until they retire; called just after a falling edge.
   task automatic run_instr(input int force_stall, input bit rand_stall);
      logic [XLEN-1:0] a, fb, b, res, tgt;
      logic            is_mul, taken, exp_ready, exp_src;
      bit              accepted, done;
      int              after, cyc;
      a      = fwd_val(fwd_a, rd1_e);
      fb     = fwd_val(fwd_b, rd2_e);
      b      = alu_src_e ? imm_e : fb;
      is_mul = (alu_ctrl_e == 4'd10) || (alu_ctrl_e == 4'd11);
      res    = alu_ref(alu_ctrl_e, a, b);
      taken  = br_ref(br_funct3, a, fb);
      tgt    = jalr_e ? ((a + imm_e) & ~XLEN'(1)) : (pc_e + imm_e);
      exp_q.push_back(res);
      accepted = 0; after = 0; done = 0; cyc = 0; obs_low = 0;
      while (!done) begin
         if (cyc < force_stall) stall_m = 1'b1;
         else if (rand_stall)   stall_m = ($urandom_range(0, 3) == 0);
         else                   stall_m = 1'b0;
         #1;
         if (is_mul) exp_ready = !stall_m && accepted && (after >= XLEN);
         else        exp_ready = !stall_m;
         check("ready_e", ready_e, exp_ready);
         if (!ready_e) obs_low++;
         exp_src = exp_ready && (jump_e || (branch_e && taken));
         check("pc_src_e", pc_src_e, exp_src);
         obs_pc_src = pc_src_e;
         obs_target = pc_target_e;
         if (exp_src) check("pc_target_e", pc_target_e, tgt);
         @(posedge clk);
         #1;
         if (is_mul && !accepted && !stall_m) begin
            accepted = 1;
            after    = 0;
         end else if (accepted) begin
            after++;
         end
         if (!stall_m) begin
            if (exp_ready) begin
               m_valid = 1; m_rw = reg_write_e; m_mw = mem_write_e; m_rs = result_src_e;
               m_rd = rd_e; m_pc4 = pc_plus4_e; m_wd = fb; m_alu = exp_q.pop_front();
               done = 1;
            end else begin
               m_valid = 0; m_rw = 0; m_mw = 0;
            end
         end
         check_m();
         cyc++;
         if (!done && cyc > 4 * XLEN + 40) begin
            n_vec++;
            n_err++;
            $display("FAIL retire_timeout: no retire after %0d cycles, op %0d", cyc, alu_ctrl_e);
            exp_q.delete();
            done = 1;
         end
         if (!done) @(negedge clk);
      end
   endtask

   // Stimulus
   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      clear_fields();
      valid_e = 0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid_m", valid_m, 1'b0);
      check("rst_alu_result_m", alu_result_m, '0);
      check("rst_rd_m", rd_m, '0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("idle_ready_e", ready_e, 1'b1);

      // ADD with writeback forwarding on A
      @(negedge clk);
      clear_fields();
      rd1_e = 5; fwd_a = 2'b01; result_w = 7; rd2_e = 3;
      run_instr(0, 0);
      check("add_fwd_result", alu_result_m, 32'd10);
      check("add_fwd_valid", valid_m, 1'b1);

      // BLT taken / BLTU not taken with the same operands
      @(negedge clk);
      clear_fields();
      branch_e = 1; br_funct3 = 3'b100; rd1_e = 32'hFFFF_FFFF; rd2_e = 1; pc_e = 32'h100; imm_e = 32'h20;
      run_instr(0, 0);
      check("blt_pc_src", obs_pc_src, 1'b1);
      check("blt_target", obs_target, 32'h120);
      @(negedge clk);
      br_funct3 = 3'b110;
      run_instr(0, 0);
      check("bltu_pc_src", obs_pc_src, 1'b0);

      // MUL / MULHU latency and results
      @(negedge clk);
      clear_fields();
      alu_ctrl_e = 4'd10; rd1_e = 32'hFFFF_FFFF; rd2_e = 2;
      run_instr(0, 0);
      check("mul_ready_low_cycles", obs_low, XLEN + 1);
      check("mul_result", alu_result_m, 32'hFFFF_FFFE);
      @(negedge clk);
      alu_ctrl_e = 4'd11;
      run_instr(0, 0);
      check("mulhu_result", alu_result_m, 32'h0000_0001);

      // M stall holds rd_m=3 while a jump waits in E
      @(negedge clk);
      clear_fields();
      rd_e = 5'd3; rd1_e = 32'h40; imm_e = 32'h4; alu_src_e = 1;
      run_instr(0, 0);
      @(negedge clk);
      clear_fields();
      jump_e = 1; rd_e = 5'd9; rd1_e = 32'h11; rd2_e = 32'h22; pc_e = 32'h200; imm_e = 32'h10;
      run_instr(3, 0);
      check("stall_release_rd", rd_m, 5'd9);

      // Flush a multiply with the counter at 10
      @(negedge clk);
      clear_fields();
      alu_ctrl_e = 4'd10; rd1_e = 32'h1234; rd2_e = 32'h55;
      #1;
      check("mul_accept_ready", ready_e, 1'b0);
      @(posedge clk);
      m_valid = 0; m_rw = 0; m_mw = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("mul_busy", busy, 1'b1);
      flush_e = 1;
      #1;
      check("flush_ready_e", ready_e, 1'b0);
      check("flush_pc_src", pc_src_e, 1'b0);
      @(posedge clk);
      #1;
      check("flush_busy", busy, 1'b0);
      check("flush_valid_m", valid_m, 1'b0);
      @(negedge clk);
      flush_e = 0; valid_e = 0;
      #1;
      check("post_flush_ready", ready_e, 1'b1);
      @(posedge clk);
      #1;
      check("post_flush_valid_m", valid_m, 1'b0);
      @(negedge clk);
      clear_fields();
      rd1_e = 32'h77; rd2_e = 32'h11; alu_ctrl_e = 4'd1;
      run_instr(0, 0);

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      clear_fields();
      alu_ctrl_e = 4'd11; rd1_e = 32'hDEAD_BEEF; rd2_e = 32'h1234_5678;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid_m", valid_m, 1'b0);
      check("arst_reg_write_m", reg_write_m, 1'b0);
      check("arst_alu_result_m", alu_result_m, '0);
      check("arst_pc_plus4_m", pc_plus4_m, '0);
      check("arst_write_data_m", write_data_m, '0);
      check("arst_busy", busy, 1'b0);
      model_clear();
      @(negedge clk);
      valid_e = 0;
      rst = 1'b1;
      @(negedge clk);
      clear_fields();
      rd1_e = 32'h100; rd2_e = 32'h23;
      run_instr(0, 0);
      check("arst_add_result", alu_result_m, 32'h123);

      // Random instruction stream with random M stalls
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         rand_fields();
         run_instr(0, 1);
      end

      @(negedge clk);
      valid_e = 0;
      stall_m = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
